// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM sequencing fetch/decode/execute/memory/writeback with ALU decode and retire counter
module multicycle_control (
   input  logic        clk,
   input  logic        reset,
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   input  logic        funct7b5,
   input  logic        zero,
   output logic        PCWrite,
   output logic        IorD,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        IRWrite,
   output logic        MemtoReg,
   output logic        RegWrite,
   output logic        ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [3:0]  ALUControl,
   output logic        PCSource,
   output logic        instr_done,
   output logic [31:0] retired,
   output logic [3:0]  state
);
   typedef enum logic [3:0] {
      FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4, MEMWR = 4'd5,
      EXEC_R = 4'd6, EXEC_I = 4'd7, ALUWB = 4'd8, BEQ = 4'd9, PCINC = 4'd10
   } state_t;
   localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                          OP_I = 7'b0010011, OP_BEQ = 7'b1100011;
   localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR = 4'b0001, ALU_ADD = 4'b0010, ALU_SUB = 4'b0110;
   state_t cur, nxt;
   logic pc_w, ir_w, reg_w, mem_w, done, pc4;
   logic [3:0] alu_i, alu_r;
   assign alu_i = funct3 == 3'b111 ? ALU_AND : funct3 == 3'b110 ? ALU_OR : ALU_ADD;
   assign alu_r = (funct3 == 3'b000 && funct7b5) ? ALU_SUB : alu_i;
   // Write enables and the retire pulse are suppressed while reset is held
   assign PCWrite    = pc_w & ~reset;
   assign IRWrite    = ir_w & ~reset;
   assign RegWrite   = reg_w & ~reset;
   assign MemWrite   = mem_w & ~reset;
   assign instr_done = done & ~reset;
   assign state      = cur;
   // State register
   always_ff @(posedge clk) begin
      if (reset) cur <= FETCH;
      else cur <= nxt;
   end
   // Retired-instruction counter, wraps naturally at 32 bits
   always_ff @(posedge clk) begin
      if (reset) retired <= '0;
      else if (instr_done) retired <= retired + 32'd1;
   end
   // Next-state and control outputs; the PC+4 group closes every non-branch instruction
   always_comb begin
      nxt = FETCH;
      pc_w = 1'b0;
      ir_w = 1'b0;
      reg_w = 1'b0;
      mem_w = 1'b0;
      done = 1'b0;
      pc4 = 1'b0;
      IorD = 1'b0;
      MemRead = 1'b0;
      MemtoReg = 1'b0;
      ALUSrcA = 1'b0;
      ALUSrcB = 2'b00;
      ALUControl = ALU_ADD;
      PCSource = 1'b0;
      case (cur)
         FETCH: begin
            MemRead = 1'b1;
            ir_w = 1'b1;
            nxt = DECODE;
         end
         DECODE: begin
            ALUSrcB = 2'b10;
            nxt = (opcode == OP_LW || opcode == OP_SW) ? MEMADR :
                  opcode == OP_R ? EXEC_R : opcode == OP_I ? EXEC_I :
                  opcode == OP_BEQ ? BEQ : PCINC;
         end
         MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            nxt = opcode == OP_LW ? MEMRD : MEMWR;
         end
         MEMRD: begin
            IorD = 1'b1;
            MemRead = 1'b1;
            nxt = MEMWB;
         end
         MEMWB: begin
            reg_w = 1'b1;
            MemtoReg = 1'b1;
            pc4 = 1'b1;
         end
         MEMWR: begin
            IorD = 1'b1;
            mem_w = 1'b1;
            pc4 = 1'b1;
         end
         EXEC_R: begin
            ALUSrcA = 1'b1;
            ALUControl = alu_r;
            nxt = ALUWB;
         end
         EXEC_I: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            ALUControl = alu_i;
            nxt = ALUWB;
         end
         ALUWB: begin
            reg_w = 1'b1;
            pc4 = 1'b1;
         end
         BEQ: begin
            ALUSrcA = 1'b1;
            ALUControl = ALU_SUB;
            PCSource = 1'b1;
            pc_w = zero;
            done = zero;
            nxt = zero ? FETCH : PCINC;
         end
         PCINC: pc4 = 1'b1;
         default: nxt = FETCH;
      endcase
      if (pc4) begin
         ALUSrcB = 2'b01;
         pc_w = 1'b1;
         done = 1'b1;
      end
   end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: randomized and directed checks of the multicycle control FSM against an instruction-level model
module tb_multicycle_control;
   logic clk = 1'b0, reset = 1'b1;
   logic [6:0] opcode = '0;
   logic [2:0] funct3 = '0;
   logic funct7b5 = 1'b0, zero = 1'b0;
   logic PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, ALUSrcA, PCSource, instr_done;
   logic [1:0] ALUSrcB;
   logic [3:0] ALUControl, state;
   logic [31:0] retired;
   int total = 0, passed = 0;
   logic [31:0] exp_ret = '0;

   always #5 clk = ~clk;

   multicycle_control dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
      .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALUControl(ALUControl), .PCSource(PCSource), .instr_done(instr_done), .retired(retired), .state(state)
   );

   function automatic logic [3:0] exp_alu(input logic [2:0] f3, input logic f7, input bit is_r);
      if (f3 == 3'd7) return 4'b0000;
      if (f3 == 3'd6) return 4'b0001;
      if (f3 == 3'd0 && is_r && f7) return 4'b0110;
      return 4'b0010;
   endfunction

   // Runs one whole instruction, checking every cycle against the instruction-level expectation
   task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic taken);
      int seq[$];
      bit is_lw = op == 7'b0000011, is_sw = op == 7'b0100011, is_r = op == 7'b0110011;
      bit is_i = op == 7'b0010011, is_beq = op == 7'b1100011;
      bit wr = is_lw || is_r || is_i;
      if (is_lw) seq = '{0, 1, 2, 3, 4};
      else if (is_sw) seq = '{0, 1, 2, 5};
      else if (is_r) seq = '{0, 1, 6, 8};
      else if (is_i) seq = '{0, 1, 7, 8};
      else if (is_beq) seq = taken ? '{0, 1, 9} : '{0, 1, 9, 10};
      else seq = '{0, 1, 10};
      for (int i = 0; i < seq.size(); i++) begin
         bit last = i == seq.size() - 1;
         logic [6:0] fl, fe;
         logic ea = 1'b0, ep = 1'b0, em = 1'b0;
         logic [1:0] eb = 2'b00;
         logic [3:0] ec = 4'b0010;
         opcode = i == 0 ? 7'($urandom) : op;
         funct3 = i == 2 ? f3 : 3'($urandom);
         funct7b5 = i == 2 ? f7 : 1'($urandom);
         zero = (is_beq && i == 2) ? taken : 1'($urandom);
         #1;
         total++;
         if (state !== 4'(seq[i])) $display("FAIL state op=%b cyc%0d: got %0d want %0d", op, i, state, seq[i]);
         else passed++;
         fe = {last, last, i == 0, i == 0 || (is_lw && i == 3), last && wr, last && is_sw, (is_lw || is_sw) && i == 3};
         fl = {instr_done, PCWrite, IRWrite, MemRead, RegWrite, MemWrite, IorD};
         total++;
         if (fl !== fe) $display("FAIL enables op=%b cyc%0d: got %b want %b", op, i, fl, fe);
         else passed++;
         if (i == 1) eb = 2'b10;
         if (i == 2 && (is_lw || is_sw || is_r || is_i || is_beq)) begin
            ea = 1'b1;
            eb = (is_r || is_beq) ? 2'b00 : 2'b10;
            ec = is_beq ? 4'b0110 : (is_r || is_i) ? exp_alu(f3, f7, is_r) : 4'b0010;
            ep = is_beq;
         end else if (last) begin
            eb = 2'b01;
            em = is_lw;
         end
         total++;
         if ({ALUSrcA, ALUSrcB, ALUControl, PCSource, MemtoReg} !== {ea, eb, ec, ep, em})
            $display("FAIL muxes op=%b cyc%0d: got %b want %b", op, i,
                     {ALUSrcA, ALUSrcB, ALUControl, PCSource, MemtoReg}, {ea, eb, ec, ep, em});
         else passed++;
         @(posedge clk);
         #1;
      end
      exp_ret++;
      total++;
      if (retired !== exp_ret) $display("FAIL retired op=%b: got %0d want %0d", op, retired, exp_ret);
      else passed++;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int c = 0; c < 2; c++) begin
         opcode = 7'($urandom);
         zero = 1'($urandom);
         #1;
         total++;
         if ({PCWrite, IRWrite, RegWrite, MemWrite, instr_done} !== 5'b0)
            $display("FAIL reset_enables c%0d: got %b want 00000", c, {PCWrite, IRWrite, RegWrite, MemWrite, instr_done});
         else passed++;
         @(posedge clk);
         #1;
      end
      total++;
      if ({state, retired} !== 36'd0) $display("FAIL reset_state: got state=%0d retired=%0d want 0/0", state, retired);
      else passed++;
      reset = 1'b0;
      #1;
      total++;
      if ({state, IRWrite, MemRead} !== {4'd0, 2'b11})
         $display("FAIL post_reset_fetch: got state=%0d IRWrite=%b MemRead=%b want 0/1/1", state, IRWrite, MemRead);
      else passed++;
      exp_ret = '0;
   endtask

   task automatic test_directed();
      run_instr(7'b0010011, 3'b000, 1'b0, 1'b0);
      run_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
      run_instr(7'b1100011, 3'b000, 1'b0, 1'b1);
      run_instr(7'b1100011, 3'b000, 1'b0, 1'b0);
      run_instr(7'b0110011, 3'b000, 1'b1, 1'b0);
      run_instr(7'b0110011, 3'b110, 1'b0, 1'b0);
      run_instr(7'b0110011, 3'b111, 1'b0, 1'b0);
      run_instr(7'b0010011, 3'b000, 1'b1, 1'b0);
      run_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
      run_instr(7'h7F, 3'b000, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      logic [6:0] ops [5] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011};
      for (int n = 0; n < 60; n++) begin
         int k = $urandom_range(0, 5);
         logic [6:0] op = 7'($urandom);
         if (k < 5) op = ops[k];
         else foreach (ops[j]) if (op == ops[j]) op = 7'h7F;
         run_instr(op, 3'($urandom), 1'($urandom), 1'($urandom));
      end
   endtask

   task automatic test_reset_mid(input logic [6:0] op, input logic [2:0] f3, input int k, input logic [3:0] st);
      opcode = op;
      funct3 = f3;
      zero = 1'b0;
      repeat (k) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      total++;
      if ({state, PCWrite, IRWrite, RegWrite, MemWrite, instr_done} !== {st, 5'b0})
         $display("FAIL reset_mid_enables st=%0d: got state=%0d en=%b want 00000", st, state,
                  {PCWrite, IRWrite, RegWrite, MemWrite, instr_done});
      else passed++;
      @(posedge clk);
      #1;
      reset = 1'b0;
      total++;
      if ({state, retired} !== 36'd0) $display("FAIL reset_mid_after st=%0d: got state=%0d retired=%0d want 0/0", st, state, retired);
      else passed++;
      exp_ret = '0;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_reset_mid(7'b0000011, 3'b010, 3, 4'd3);
      run_instr(7'b0010011, 3'b111, 1'b0, 1'b0);
      test_reset_mid(7'b0110011, 3'b000, 3, 4'd8);
      test_back_to_back();
      test_reset_mid(7'b1100011, 3'b000, 2, 4'd9);
      run_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control unit for the multicycle RV32I-subset core. A Moore-style finite state machine (FSM) that decodes the opcode held in the instruction register. It sequences fetch, decode, execute, memory and writeback over 3–5 cycles, and drives every mux select and write enable in the datapath: PC, memory, IR, register file, ALU and operand muxes. It also contains the ALU-control decoder and a retired-instruction counter.

## Interface
- No parameters.
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7b5  in  1  IR[30]
- zero  in  1  ALU zero flag (combinational, current cycle)
- PCWrite  out  1  PC load enable (includes branch condition)
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read enable
- MemWrite  out  1  memory write enable
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  register writeback source: 0 = ALUOut, 1 = MDR
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  ALU A source: 0 = PC, 1 = A register
- ALUSrcB  out  2  ALU B source: 00 = B register, 01 = constant 4, 10 = immediate
- ALUControl  out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB
- PCSource  out  1  PC source: 0 = ALU result, 1 = ALUOut
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction
- retired  out  32  retired-instruction count
- state  out  4  current state encoding (debug)

## Operation
- State encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC_R=6, EXEC_I=7, ALUWB=8, BEQ=9, PCINC=10.
  - Encodings 11–15 go to FETCH with all outputs at their defaults.
- Defaults, applying to any signal not listed for a state: all enables 0, ALUSrcA=0, ALUSrcB=00, ALUControl=0010, IorD=0, MemtoReg=0, PCSource=0.
- State actions:
  - FETCH: MemRead=1, IRWrite=1. The PC is not updated here. Next state is DECODE.
  - DECODE: ALUSrcB=10, ADD, so ALUOut is loaded with PC+imm (branch target). Next state by opcode:
    - 0000011 (lw) or 0100011 (sw) → MEMADR
    - 0110011 (R-type) → EXEC_R
    - 0010011 (I-type) → EXEC_I
    - 1100011 (beq) → BEQ
    - any other opcode → PCINC (executed as a NOP)
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ADD. Next state is MEMRD for lw, MEMWR for sw.
  - MEMRD: IorD=1, MemRead=1. The MDR captures the load data. Next state is MEMWB.
  - MEMWB: RegWrite=1, MemtoReg=1, plus the PC+4 group. Next state is FETCH.
  - MEMWR: IorD=1, MemWrite=1, plus the PC+4 group. Next state is FETCH.
  - EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUControl from the funct decoder. Next state is ALUWB.
  - EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUControl from the funct decoder with funct7b5 ignored. Next state is ALUWB.
  - ALUWB: RegWrite=1, MemtoReg=0, plus the PC+4 group. Next state is FETCH.
  - BEQ: ALUSrcA=1, ALUSrcB=00, SUB, PCSource=1, PCWrite=zero. Next state is FETCH if zero=1, otherwise PCINC.
  - PCINC: the PC+4 group only. Next state is FETCH.
- PC+4 group: ALUSrcA=0, ALUSrcB=01, ADD, PCSource=0, PCWrite=1. This reuses the idle ALU in the final cycle of the instruction.
- Funct decoder:
  - funct3=000: SUB if funct7b5=1 (R-type only), otherwise ADD.
  - funct3=111: AND.
  - funct3=110: OR.
  - any other funct3: ADD.
- instr_done=1 in MEMWB, MEMWR, ALUWB, PCINC, and in BEQ when zero=1.
- retired increments by 1 on every clock edge where instr_done=1, wrapping from 0xFFFFFFFF to 0.

## Timing
- Reset (synchronous):
  - State goes to FETCH and retired goes to 0 on the next edge.
  - While reset=1, PCWrite, IRWrite, RegWrite, MemWrite and instr_done are forced to 0 regardless of state.
  - Reset asserted mid-instruction abandons the instruction with no writes and no retire count.
- After reset is released, the first cycle is FETCH, with MemRead=1 and IRWrite=1 asserted.
- The opcode is sampled in DECODE; it is valid because the IR loaded at the end of FETCH.
- Latency per instruction:
  - lw: 5 cycles
  - sw, R-type, I-type: 4 cycles
  - beq taken: 3 cycles
  - beq not taken: 4 cycles
  - illegal opcode: 3 cycles
- Output dependencies:
  - All outputs are functions of state only, except PCWrite and instr_done in BEQ, which follow zero combinationally in the same cycle.
  - ALUControl additionally depends on funct3/funct7b5 in EXEC_R and EXEC_I.
- The register file write and the PC+4 update occur on the same edge. RegWrite uses ALUOut as latched in the prior cycle, not the PC+4 result.

## Test plan
- Reset held 2 cycles, then released → state=0, retired=0, write enables 0 during reset; first post-reset cycle has IRWrite=1 and MemRead=1.
- addi x3,x0,20 (0x01400193) at address 0 → states 0,1,7,8; in state 7 ALUControl=0010 and ALUSrcB=10; afterwards x3=20, PC=4, retired=1.
- Following lw x8,120(x3) (0x0781A403), with mem[140]=82 → states 0,1,2,3,4; IorD=1 in state 3; afterwards x8=82, PC=8, retired=2.
- beq with equal operands (zero=1) and imm=+16 at PC=8 → states 0,1,9; PCWrite=1, PCSource=1; PC=24; 3 cycles. Unequal operands → states 0,1,9,10; PC=12.
- R-type sub (funct3=000, funct7b5=1) → ALUControl=0110 in EXEC_R. Also or → 0001, and → 0000, and sw → states 0,1,2,5 with MemWrite=1 only in state 5.
- Opcode 0x7F → states 0,1,10, PC+=4, no RegWrite/MemWrite. Reset asserted in MEMRD → no RegWrite, next state FETCH, retired=0.
